// File: rtl/seq_tx.sv
// Serial frame transmitter: sends a captured WIDTH-bit frame MSB first, (reps+1) times back to back,
// then pulses done for one cycle. All outputs are registered.
module seq_tx #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = 5'b10110
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             use_pat,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       reps,
  output logic             ser_out,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] frame_q, frame_n, load_frame;
  logic [IW-1:0]    idx_q, idx_n, idx_m1;
  logic [3:0]       cnt_q, cnt_n;
  logic             ser_n, busy_n, fe_n, done_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ser_out   <= 1'b0;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_q   <= frame_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      ser_out   <= ser_n;
      busy      <= busy_n;
      frame_end <= fe_n;
      done      <= done_n;
    end
  end

  // idx_q is the index of the bit currently on ser_out; outputs are computed one edge ahead
  always_comb begin
    state_n    = state;
    frame_n    = frame_q;
    idx_n      = idx_q;
    cnt_n      = cnt_q;
    ser_n      = 1'b0;
    busy_n     = 1'b0;
    fe_n       = 1'b0;
    done_n     = 1'b0;
    idx_m1     = idx_q - 1'b1;
    load_frame = use_pat ? PATTERN : data_in;
    case (state)
      // The DONE cycle doubles as the accept slot so a held start repeats with a single gap cycle
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          state_n = SHIFT;
          frame_n = load_frame;
          cnt_n   = reps;
          idx_n   = IDX_TOP;
          ser_n   = load_frame[WIDTH-1];
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_q == '0) begin
          if (cnt_q != 4'd0) begin
            cnt_n  = cnt_q - 4'd1;
            idx_n  = IDX_TOP;
            ser_n  = frame_q[WIDTH-1];
            busy_n = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          idx_n  = idx_m1;
          ser_n  = frame_q[idx_m1];
          busy_n = 1'b1;
          fe_n   = (idx_m1 == '0);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: table-driven transfers, hand-written corner sequences,
// and a randomized run checked cycle by cycle against a queue-based reference model.
module tb_seq_tx;
  localparam int WIDTH = 5;
  localparam logic [4:0] PAT = 5'b10110;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       use_pat = 1'b0;
  logic [4:0] data_in = '0;
  logic [3:0] reps = '0;
  logic       ser_out, busy, frame_end, done;

  seq_tx #(.WIDTH(WIDTH), .PATTERN(PAT)) dut (
    .clock(clock), .reset(reset), .start(start), .use_pat(use_pat),
    .data_in(data_in), .reps(reps), .ser_out(ser_out), .busy(busy),
    .frame_end(frame_end), .done(done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: an accepted start enqueues every expected output cycle of the transfer
  typedef struct packed {logic ser; logic bsy; logic fe; logic dn;} obs_t;
  obs_t       exp_q[$];
  obs_t       cur;
  logic [4:0] m_frame;

  always @(negedge reset) exp_q.delete();

  always @(posedge clock) begin
    if (!reset) begin
      exp_q.delete();
      cur = '0;
    end else begin
      if (exp_q.size() == 0 && start) begin
        m_frame = use_pat ? PAT : data_in;
        for (int r = 0; r <= int'(reps); r++)
          for (int b = WIDTH - 1; b >= 0; b--)
            exp_q.push_back('{m_frame[b], 1'b1, (b == 0), 1'b0});
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
      end
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
    end
    #1;
    if (reset) check("model", {28'd0, ser_out, busy, frame_end, done}, {28'd0, cur});
  end

  typedef struct {
    logic       up;
    logic [4:0] din;
    logic [3:0] rp;
    logic [4:0] ef;
    int         elen;
    int         efe;
    int         edet;
  } vec_t;
  vec_t vt[6];

  task automatic run_vec(input int i);
    int nbits = 0, fe = 0, errs = 0, done_at = -1, det = 0, extra = 0;
    logic [4:0] hist = '0;
    logic [4:0] ef = vt[i].ef;
    @(negedge clock);
    use_pat = vt[i].up; data_in = vt[i].din; reps = vt[i].rp; start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      hist = {hist[3:0], ser_out};
      if (hist == 5'b10110) det++;
      if (busy) begin
        if (ser_out !== ef[WIDTH - 1 - (nbits % WIDTH)]) errs++;
        nbits++;
      end
      if (frame_end) fe++;
      if (done) begin done_at = c; break; end
      @(negedge clock);
      if (c == 0) begin
        start = 1'b0; data_in = 5'($urandom); use_pat = 1'($urandom); reps = 4'($urandom);
      end
      if (c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
    end
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      if (done) extra++;
    end
    check($sformatf("v%0d_len", i), nbits, vt[i].elen);
    check($sformatf("v%0d_frame_end", i), fe, vt[i].efe);
    check($sformatf("v%0d_stream_err", i), errs, 0);
    check($sformatf("v%0d_done_at", i), done_at, vt[i].elen);
    check($sformatf("v%0d_detect", i), det, vt[i].edet);
    check($sformatf("v%0d_extra_done", i), extra, 0);
  endtask

  initial begin
    int dcnt;
    logic [4:0] patv;
    patv = PAT;
    vt[0] = '{1'b1, 5'b00000, 4'd0,  5'b10110, 5,  1,  1};
    vt[1] = '{1'b0, 5'b11001, 4'd2,  5'b11001, 15, 3,  0};
    vt[2] = '{1'b0, 5'b00001, 4'd0,  5'b00001, 5,  1,  0};
    vt[3] = '{1'b1, 5'b11111, 4'd1,  5'b10110, 10, 2,  2};
    vt[4] = '{1'b0, 5'b10000, 4'd15, 5'b10000, 80, 16, 0};
    vt[5] = '{1'b0, 5'b01010, 4'd3,  5'b01010, 20, 4,  0};

    // Reset state
    @(posedge clock); #1;
    check("reset_outputs", {ser_out, busy, frame_end, done}, 4'b0000);

    // Start high on the first edge after reset release
    @(negedge clock);
    use_pat = 1'b1; reps = 4'd0; start = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    check("first_edge_start", {ser_out, busy}, 2'b11);
    @(negedge clock); start = 1'b0;
    repeat (8) @(posedge clock);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset asserted on the third bit of a frame
    @(negedge clock);
    use_pat = 1'b1; reps = 4'd0; start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    check("pre_reset_bit3", {ser_out, busy}, 2'b11);
    #1 reset = 1'b0;
    #1;
    check("async_reset_out", {ser_out, busy, frame_end, done}, 4'b0000);
    dcnt = 0;
    repeat (3) begin @(posedge clock); #1; if (done) dcnt++; end
    @(negedge clock); reset = 1'b1;
    repeat (6) begin @(posedge clock); #1; if (done) dcnt++; end
    check("no_done_after_abort", dcnt, 0);
    run_vec(0);

    // Start held high: 10 pattern bits, one DONE cycle, repeat
    @(negedge clock);
    use_pat = 1'b1; reps = 4'd1; start = 1'b1; data_in = 5'($urandom);
    for (int c = 0; c < 33; c++) begin
      int k;
      @(posedge clock); #1;
      k = c % 11;
      if (k < 10) check($sformatf("held_c%0d", c), {ser_out, busy, done}, {patv[4 - (k % 5)], 2'b10});
      else        check($sformatf("held_c%0d", c), {ser_out, busy, done}, 3'b001);
    end
    @(negedge clock); start = 1'b0;
    repeat (12) @(posedge clock);

    // Randomized traffic checked by the reference model
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      reset   = ($urandom_range(0, 149) != 0);
      start   = ($urandom_range(0, 9) < 3);
      use_pat = 1'($urandom);
      data_in = 5'($urandom);
      reps    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
    end
    @(negedge clock); reset = 1'b1; start = 1'b0;
    repeat (100) @(posedge clock);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
